// File: rtl/tinyqv_prefetch_pkg.sv
// Shared types for the TinyQV instruction prefetch buffer: fetch FSM states
// and the encoding of how many halfwords the decoder consumes per cycle.
package tinyqv_prefetch_pkg;

    typedef enum logic [1:0] {
        RESTART    = 2'd0,
        FETCH      = 2'd1,
        WAIT_SPACE = 2'd2
    } state_t;

    localparam logic [1:0] ADV_NONE = 2'd0;
    localparam logic [1:0] ADV_16   = 2'd1;
    localparam logic [1:0] ADV_32   = 2'd2;

endpackage

// File: rtl/tinyqv_hw_fifo.sv
// Circular halfword buffer: one write per cycle, pop of 0/1/2 entries, and a
// two-entry read window at the head. Empty window halves read as zero.
module tinyqv_hw_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [15:0]   i_wr_data,
    input  logic [1:0]    i_pop,
    output logic [15:0]   o_hw0,
    output logic [15:0]   o_hw1,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_next
);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_rd_ptr1;
    logic          w_wr;

    assign w_wr      = i_wr_en && !i_flush;
    assign w_rd_ptr1 = r_rd_ptr + PW'(1);

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (i_flush)
            w_count_next = '0;
        else
            w_count_next = r_count + CW'(i_wr_en) - CW'(i_pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(i_wr_en);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop);
            r_count  <= w_count_next;
        end
    end

    // NOTE: the storage array has no reset; validity comes from r_count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_hw0        = (r_count != '0)      ? r_mem[r_rd_ptr]  : 16'h0000;
    assign o_hw1        = (r_count >= CW'(2))  ? r_mem[w_rd_ptr1] : 16'h0000;
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch buffer between the TinyQV decoder and the memory
// controller fetch port: fetch FSM, fetch address / head PC counters, FIFO.
module tinyqv_instr_prefetch
    import tinyqv_prefetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [22:0] RESET_ADDR = 23'h000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect,
    input  logic [22:0] redirect_addr,
    input  logic [1:0]  instr_advance,
    output logic [31:0] instr_window,
    output logic        instr_valid_16,
    output logic        instr_valid_32,
    output logic [22:0] instr_pc,
    output logic [22:0] instr_addr,
    output logic        instr_fetch_restart,
    output logic        instr_fetch_stall,
    input  logic        instr_fetch_started,
    input  logic        instr_fetch_stopped,
    input  logic [15:0] instr_data,
    input  logic        instr_ready
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t        r_state;
    logic          r_restart;
    logic          r_redirect_d;
    logic [22:0]   r_addr;
    logic [22:0]   r_head_pc;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic [15:0]   w_hw0;
    logic [15:0]   w_hw1;
    logic          w_full;
    logic          w_write;
    logic [1:0]    w_pop;
    logic          w_start_ok;

    assign w_full     = (w_count == FULL);
    assign w_write    = (r_state == FETCH) && instr_ready && !redirect && !w_full;
    assign w_pop      = redirect ? ADV_NONE : instr_advance;
    // A started pulse right after a redirect belongs to the abandoned address.
    assign w_start_ok = instr_fetch_started && !r_redirect_d;

    tinyqv_hw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .i_flush      (redirect),
        .i_wr_en      (w_write),
        .i_wr_data    (instr_data),
        .i_pop        (w_pop),
        .o_hw0        (w_hw0),
        .o_hw1        (w_hw1),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= RESTART;
            r_restart    <= 1'b1;
            r_redirect_d <= 1'b0;
            r_addr       <= RESET_ADDR;
            r_head_pc    <= RESET_ADDR;
        end else begin
            r_redirect_d <= redirect;
            if (redirect) begin
                r_state   <= RESTART;
                r_restart <= 1'b1;
                r_addr    <= redirect_addr;
                r_head_pc <= redirect_addr;
            end else begin
                r_head_pc <= r_head_pc + 23'(instr_advance);
                if (w_write)
                    r_addr <= r_addr + 23'd1;
                // Space decisions use the post-update count so a same-cycle pop frees room at once.
                unique case (r_state)
                    RESTART: begin
                        if (w_start_ok) begin
                            r_state   <= FETCH;
                            r_restart <= 1'b0;
                        end
                    end
                    FETCH: begin
                        if (instr_fetch_stopped) begin
                            if (w_count_next != FULL) begin
                                r_state   <= RESTART;
                                r_restart <= 1'b1;
                            end else begin
                                r_state <= WAIT_SPACE;
                            end
                        end
                    end
                    WAIT_SPACE: begin
                        if (w_count_next != FULL) begin
                            r_state   <= RESTART;
                            r_restart <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= RESTART;
                        r_restart <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign instr_window        = {w_hw1, w_hw0};
    assign instr_valid_16      = (w_count != '0);
    assign instr_valid_32      = (w_count >= CW'(2));
    assign instr_pc            = r_head_pc;
    assign instr_addr          = r_addr;
    assign instr_fetch_restart = r_restart;
    assign instr_fetch_stall   = w_full;

    a_advance_legal: assert property (@(posedge clk) disable iff (!rstn)
        !redirect |-> (instr_advance != 2'd3 && CW'(instr_advance) <= w_count));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        (instr_ready && !redirect && r_state != RESTART) |-> !w_full);

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// Scoreboard bench for the prefetch buffer: stimulus pushes each halfword the
// buffer must keep; a negedge monitor compares the window and pops on advance.
module tb_tinyqv_instr_prefetch;

    typedef struct {
        logic [22:0] pc;
        logic [15:0] hw;
    } entry_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic [22:0] redirect_addr = '0;
    logic [1:0]  instr_advance = 2'd0;
    logic [31:0] instr_window;
    logic        instr_valid_16;
    logic        instr_valid_32;
    logic [22:0] instr_pc;
    logic [22:0] instr_addr;
    logic        instr_fetch_restart;
    logic        instr_fetch_stall;
    logic        instr_fetch_started = 1'b0;
    logic        instr_fetch_stopped = 1'b0;
    logic [15:0] instr_data = '0;
    logic        instr_ready = 1'b0;

    entry_t      exp_q[$];
    logic [22:0] exp_addr;
    logic        mon_en = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    tinyqv_instr_prefetch #(.DEPTH(4), .RESET_ADDR(23'h000000)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .redirect            (redirect),
        .redirect_addr       (redirect_addr),
        .instr_advance       (instr_advance),
        .instr_window        (instr_window),
        .instr_valid_16      (instr_valid_16),
        .instr_valid_32      (instr_valid_32),
        .instr_pc            (instr_pc),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data          (instr_data),
        .instr_ready         (instr_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_started();
        instr_fetch_started = 1'b1;
        tick();
        instr_fetch_started = 1'b0;
    endtask

    task automatic pulse_stopped();
        instr_fetch_stopped = 1'b1;
        tick();
        instr_fetch_stopped = 1'b0;
    endtask

    // One ready pulse; keep=1 means the buffer must retain it at exp_addr.
    task automatic deliver(input logic [15:0] d, input bit keep, input bit stop);
        entry_t e;
        check("fetch_addr", 32'(instr_addr), 32'(exp_addr));
        instr_ready = 1'b1;
        instr_data = d;
        instr_fetch_stopped = stop;
        tick();
        instr_ready = 1'b0;
        instr_fetch_stopped = 1'b0;
        if (keep) begin
            e.pc = exp_addr;
            e.hw = d;
            exp_q.push_back(e);
            exp_addr = exp_addr + 23'd1;
        end
    endtask

    task automatic advance(input logic [1:0] n);
        instr_advance = n;
        tick();
        instr_advance = 2'd0;
    endtask

    task automatic do_redirect(input logic [22:0] a, input bit with_ready);
        redirect = 1'b1;
        redirect_addr = a;
        instr_ready = with_ready;
        instr_data = 16'hDEAD;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b0;
        exp_q.delete();
        exp_addr = a;
    endtask

    // Monitor: compares the window against the scoreboard and pops on consumption.
    always @(negedge clk) begin
        if (rstn && mon_en) begin
            check("valid_16", 32'(instr_valid_16), 32'(exp_q.size() >= 1));
            check("valid_32", 32'(instr_valid_32), 32'(exp_q.size() >= 2));
            check("stall", 32'(instr_fetch_stall), 32'(exp_q.size() == 4));
            if (exp_q.size() >= 1) begin
                check("hw0", 32'(instr_window[15:0]), 32'(exp_q[0].hw));
                check("pc", 32'(instr_pc), 32'(exp_q[0].pc));
            end else begin
                check("hw0_zero", 32'(instr_window[15:0]), 32'h0);
            end
            if (exp_q.size() >= 2)
                check("hw1", 32'(instr_window[31:16]), 32'(exp_q[1].hw));
            else
                check("hw1_zero", 32'(instr_window[31:16]), 32'h0);
            if (!redirect) begin
                for (int k = 0; k < int'(instr_advance); k++)
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        exp_addr = 23'h000000;
        idle(2);
        rstn = 1'b1;

        // Reset state
        check("rst_restart", 32'(instr_fetch_restart), 32'h1);
        check("rst_valid16", 32'(instr_valid_16), 32'h0);
        check("rst_valid32", 32'(instr_valid_32), 32'h0);
        check("rst_stall", 32'(instr_fetch_stall), 32'h0);
        check("rst_window", instr_window, 32'h0);
        check("rst_addr", 32'(instr_addr), 32'h0);
        check("rst_pc", 32'(instr_pc), 32'h0);
        mon_en = 1'b1;

        // 1: first fetch
        idle(1);
        pulse_started();
        check("t1_restart_low", 32'(instr_fetch_restart), 32'h0);
        deliver(16'h0013, 1'b1, 1'b0);
        idle(3);
        deliver(16'h4501, 1'b1, 1'b0);
        check("t1_window", instr_window, 32'h45010013);
        check("t1_valid32", 32'(instr_valid_32), 32'h1);
        check("t1_pc", 32'(instr_pc), 32'h0);
        check("t1_addr", 32'(instr_addr), 32'h2);
        idle(3);

        // 2: fill to full, then drain two
        deliver(16'h1111, 1'b1, 1'b0);
        idle(3);
        deliver(16'h2222, 1'b1, 1'b0);
        check("t2_stall_full", 32'(instr_fetch_stall), 32'h1);
        idle(3);
        advance(2'd2);
        check("t2_stall_drop", 32'(instr_fetch_stall), 32'h0);
        check("t2_pc", 32'(instr_pc), 32'h2);
        check("t2_window", instr_window, 32'h22221111);
        deliver(16'h3333, 1'b1, 1'b0);
        check("t2_addr", 32'(instr_addr), 32'h5);
        idle(3);

        // 3: redirect with same-cycle ready, stale started and stale ready
        do_redirect(23'h000100, 1'b1);
        check("t3_valid16", 32'(instr_valid_16), 32'h0);
        check("t3_restart", 32'(instr_fetch_restart), 32'h1);
        check("t3_addr", 32'(instr_addr), 32'h100);
        check("t3_pc", 32'(instr_pc), 32'h100);
        pulse_started();
        check("t3_stale_start", 32'(instr_fetch_restart), 32'h1);
        deliver(16'hBAD0, 1'b0, 1'b0);
        check("t3_stale_ready", 32'(instr_valid_16), 32'h0);
        check("t3_stale_addr", 32'(instr_addr), 32'h100);
        pulse_started();
        check("t3_fetch", 32'(instr_fetch_restart), 32'h0);
        deliver(16'hA001, 1'b1, 1'b0);
        idle(3);
        deliver(16'hA002, 1'b1, 1'b0);
        idle(3);

        // 4: stop with count=2, resume; then stop together with ready
        pulse_stopped();
        check("t4_restart", 32'(instr_fetch_restart), 32'h1);
        check("t4_addr", 32'(instr_addr), 32'h102);
        pulse_started();
        deliver(16'hA003, 1'b1, 1'b0);
        idle(3);
        advance(2'd1);
        deliver(16'hA004, 1'b1, 1'b1);
        check("t4_stop_ready_restart", 32'(instr_fetch_restart), 32'h1);
        check("t4_stop_ready_addr", 32'(instr_addr), 32'h104);
        pulse_started();
        deliver(16'hA005, 1'b1, 1'b0);
        idle(3);

        // 5: stop while full waits for space
        pulse_stopped();
        check("t5_wait_restart", 32'(instr_fetch_restart), 32'h0);
        check("t5_wait_stall", 32'(instr_fetch_stall), 32'h1);
        idle(2);
        check("t5_still_wait", 32'(instr_fetch_restart), 32'h0);
        advance(2'd1);
        check("t5_restart", 32'(instr_fetch_restart), 32'h1);
        check("t5_window", instr_window, 32'hA004A003);
        idle(2);

        // 6: address and PC wrap
        do_redirect(23'h7FFFFF, 1'b0);
        idle(1);
        pulse_started();
        deliver(16'hBEEF, 1'b1, 1'b0);
        check("t6_addr_wrap", 32'(instr_addr), 32'h0);
        idle(3);
        deliver(16'hCAFE, 1'b1, 1'b0);
        check("t6_addr", 32'(instr_addr), 32'h1);
        check("t6_pc", 32'(instr_pc), 32'h7FFFFF);
        idle(2);
        advance(2'd1);
        check("t6_pc_wrap", 32'(instr_pc), 32'h0);
        advance(2'd1);
        check("t6_empty", 32'(instr_valid_16), 32'h0);
        check("t6_pc_end", 32'(instr_pc), 32'h1);
        idle(3);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tinyqv_instr_prefetch.md
Name: tinyqv_instr_prefetch

Overview:
Instruction prefetch buffer between the TinyQV core's decoder and the memory controller's instruction-fetch port. It drives the fetch address, restart and stall controls, and captures 16-bit halfwords into a small FIFO. It presents the core with a 32-bit window of the oldest halfwords and their PC, so compressed and full-width instructions can be consumed. It handles redirects (jump/branch/trap) and resumes automatically when a data transaction pre-empts fetching.

Parameters:
DEPTH, 4, FIFO depth in halfwords; power of two, >= 2
RESET_ADDR, 23'h000000, halfword fetch address used after reset

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
redirect  in  1  core requests fetch from redirect_addr; flushes buffer
redirect_addr  in  23  new PC [23:1]
instr_advance  in  2  halfwords consumed this cycle: 0, 1 or 2
instr_window  out  32  {hw1, hw0}; hw0 = oldest buffered halfword
instr_valid_16  out  1  hw0 valid (count >= 1)
instr_valid_32  out  1  hw0 and hw1 valid (count >= 2)
instr_pc  out  23  PC [23:1] of hw0
instr_addr  out  23  fetch address to memory controller
instr_fetch_restart  out  1  request (re)start of fetch at instr_addr
instr_fetch_stall  out  1  buffer full; memory controller must hold delivery
instr_fetch_started  in  1  pulse: fetch transaction started
instr_fetch_stopped  in  1  pulse: fetch transaction stopped
instr_data  in  16  fetched halfword
instr_ready  in  1  instr_data valid

Behaviour:
- Reset (async, rstn low):
  - count=0; head_pc=RESET_ADDR; instr_addr=RESET_ADDR; state=RESTART; instr_fetch_restart=1 (from the first cycle after release).
  - instr_valid_16=0, instr_valid_32=0, instr_fetch_stall=0, instr_window=0.
  - Reset mid-transaction discards all state; no data is retained.
- States:
  - RESTART: restart=1. Move to FETCH on an accepted instr_fetch_started. A started pulse is accepted only if redirect was low in the previous cycle (registered redirect_d), because a pulse following a redirect belongs to the old address. The controller stops that transaction while restart stays high.
  - FETCH: restart=0. On each instr_ready, write instr_data to the FIFO tail and increment instr_addr by 1.
    - On instr_fetch_stopped: go to RESTART if count < DEPTH, otherwise go to WAIT_SPACE.
  - WAIT_SPACE: restart=0. Go to RESTART once count < DEPTH.
- FIFO:
  - Write-to-visible latency is 1 cycle: instr_ready in cycle N gives the halfword at the window output in cycle N+1.
  - count' = count + write - instr_advance.
  - Simultaneous write and pop are legal.
  - instr_advance greater than count is illegal (assertion).
  - head_pc += instr_advance; 23-bit arithmetic wraps modulo 2^23, as does instr_addr.
  - Invalid window halves read 0.
- instr_fetch_stall = (count == DEPTH), from the registered count.
  - instr_ready with count == DEPTH is an overflow (assertion).
  - The memory controller never delivers back-to-back readies, since QSPI needs at least 4 cycles per halfword, so the 1-cycle lag is safe.
- Redirect (highest priority):
  - Next cycle: count=0, head_pc=instr_addr=redirect_addr, state=RESTART.
  - Same-cycle instr_ready and instr_advance are ignored.
  - Any instr_ready received in RESTART is discarded (stale).
- Stop and ready in the same cycle: the halfword is kept, then the stopped transition is taken.
- Outputs are registered or derived from registered count and head state only. There are no combinational paths from memory-controller inputs to memory-controller outputs.

Decomposition:
- Package tinyqv_prefetch_pkg:
  - state encoding constants RESTART, FETCH, WAIT_SPACE;
  - advance encodings ADV_NONE, ADV_16, ADV_32.
- One sub-module, tinyqv_hw_fifo: DEPTH x 16 circular buffer, single write, 0/1/2-entry pop, dual-head read, count output, flush input.
- The top level holds the FSM, address/PC counters and the stale-start filter.

Test Plan:
1. Release reset; controller model pulses started at cycle 2, then readies for 0x0013, 0x4501 -> instr_addr 0 then 2; instr_window=0x45010013 and instr_valid_32=1 one cycle after the second ready; instr_pc=0.
2. Fill 4 halfwords with no advance -> stall=1, no further readies; instr_advance=2 -> stall drops the next cycle; fetch continues at addr 4.
3. Redirect to 0x000100 in the cycle of an instr_ready -> halfword dropped, valid_16=0, restart=1, instr_addr=0x100; started in the cycle after redirect is ignored; a later started enters FETCH.
4. In FETCH with count=2, stopped pulse -> RESTART with instr_addr preserved (e.g. 0x006); started resumes delivery; no duplicate or missing halfwords.
5. Stopped while full -> WAIT_SPACE with restart=0; advance 1 -> restart=1 the next cycle.
6. instr_addr=0x7FFFFF, one ready -> instr_addr wraps to 0; head_pc wraps the same way on advance.
